// File: rtl/uart_pkg.sv
// Shared types and constants for the UART register responder: FSM states,
// frame sync byte, response status codes and the frame checksum rule.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_DATA,
    GET_CHK,
    EXEC,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  localparam logic [7:0] SYNC_BYTE     = 8'h55;
  localparam logic [7:0] STAT_OK       = 8'hAC;
  localparam logic [7:0] STAT_BAD_CHK  = 8'hE0;
  localparam logic [7:0] STAT_BAD_CMD  = 8'hE1;
  localparam logic [7:0] STAT_BAD_ADDR = 8'hE2;

  // A write frame protects CMD and DATA; a read frame carries only CMD.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] data);
    return cmd[7] ? (cmd ^ data) : cmd;
  endfunction

endpackage

// File: rtl/uart_reg_responder.sv
// Parses SYNC/CMD/[DATA]/CHK host frames from the UART receiver, reads or
// writes a small register file and answers through the UART transmitter.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int TIMEOUT_CLKS = 104160
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic [8*NUM_REGS-1:0] reg_out,
  output logic [7:0]            err_count
);

  localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

  state_t           state, state_nxt;
  logic [7:0]       cmd_q, data_q, chk_q;
  logic [7:0]       rd_q;
  logic             pending_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       regs [NUM_REGS];

  logic       in_frame, tmo_hit, addr_ok, err_inc, do_write;
  logic [7:0] status, rd_byte;

  assign in_frame = (state == GET_CMD) || (state == GET_DATA) || (state == GET_CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit  = in_frame && !rx_valid && (tmo_cnt == CNT_W'(TIMEOUT_CLKS));
  assign addr_ok  = {1'b0, cmd_q[3:0]} < 5'(NUM_REGS);

  always_comb begin
    status = STAT_OK;
    if (chk_q != frame_chk(cmd_q, data_q))  status = STAT_BAD_CHK;
    else if (cmd_q[6:4] != 3'b000)          status = STAT_BAD_CMD;
    else if (!addr_ok)                      status = STAT_BAD_ADDR;
  end

  assign err_inc  = tmo_hit || ((state == EXEC) && (status != STAT_OK));
  assign do_write = (state == EXEC) && (status == STAT_OK) && cmd_q[7];

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_q[3:0] == 4'(i)) rd_byte = regs[i];
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) reg_out[8*i +: 8] = regs[i];
  end

  // NOTE: non-blocking assignments for every register so all state updates
  // use pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (rx_valid && rx_data == SYNC_BYTE) state_nxt = GET_CMD;
      GET_CMD:  if (rx_valid)     state_nxt = rx_data[7] ? GET_DATA : GET_CHK;
                else if (tmo_hit) state_nxt = IDLE;
      GET_DATA: if (rx_valid)     state_nxt = GET_CHK;
                else if (tmo_hit) state_nxt = IDLE;
      GET_CHK:  if (rx_valid)     state_nxt = EXEC;
                else if (tmo_hit) state_nxt = IDLE;
      EXEC:     state_nxt = SEND;
      SEND:     state_nxt = WAIT_HI;
      WAIT_HI:  if (tx_busy) state_nxt = WAIT_LO;
      WAIT_LO:  if (!tx_busy) state_nxt = pending_q ? SEND : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign tx_start = (state == SEND);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q     <= 8'h00;
      data_q    <= 8'h00;
      chk_q     <= 8'h00;
      rd_q      <= 8'h00;
      pending_q <= 1'b0;
      tx_data   <= 8'h00;
      tmo_cnt   <= '0;
      err_count <= 8'h00;
    end else begin
      if (!in_frame || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (rx_valid && state == GET_CMD)  cmd_q  <= rx_data;
      if (rx_valid && state == GET_DATA) data_q <= rx_data;
      if (rx_valid && state == GET_CHK)  chk_q  <= rx_data;

      if (state == EXEC) begin
        tx_data   <= status;
        rd_q      <= rd_byte;
        pending_q <= (status == STAT_OK) && !cmd_q[7];
      end else if (state == WAIT_LO && !tx_busy && pending_q) begin
        tx_data   <= rd_q;
        pending_q <= 1'b0;
      end

      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // NOTE: the register file is reset explicitly because host-visible
  // contents must read 0x00 after reset, so it cannot map to a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (do_write && cmd_q[3:0] == 4'(i)) regs[i] <= data_q;
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder with a simple transmitter model
// that raises tx_busy after each tx_start and holds it for BUSY cycles.
module tb_uart_reg_responder;

  localparam int NUM_REGS = 8;
  localparam int TMO      = 40;
  localparam int BUSY     = 6;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_valid = 1'b0;
  logic                  tx_busy = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic [8*NUM_REGS-1:0] reg_out;
  logic [7:0]            err_count;

  uart_reg_responder #(.NUM_REGS(NUM_REGS), .TIMEOUT_CLKS(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_busy   (tx_busy),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .reg_out   (reg_out),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int viol    = 0;
  int busy_left = 0;
  logic prev_start = 1'b0;
  logic [7:0] tx_q[$];
  int tx_cyc_q[$];
  int fall_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model and protocol monitor.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      if (tx_busy || prev_start) viol++;
      tx_q.push_back(tx_data);
      tx_cyc_q.push_back(cyc);
      tx_busy   = 1'b1;
      busy_left = BUSY;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        tx_busy = 1'b0;
        fall_q.push_back(cyc);
      end
    end
    prev_start = tx_start;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int i);
    return reg_out[8*i +: 8];
  endfunction

  // Called on a negedge; returns on the next negedge so calls chain back to back.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic clear_q();
    tx_q.delete();
    tx_cyc_q.delete();
    fall_q.delete();
  endtask

  task automatic expect_resp(input string tag, input int n, input logic [7:0] b0, input logic [7:0] b1);
    check({tag, "_nbytes"}, tx_q.size(), n);
    if (n >= 1 && tx_q.size() >= 1) check({tag, "_byte0"}, tx_q[0], b0);
    if (n >= 2 && tx_q.size() >= 2) check({tag, "_byte1"}, tx_q[1], b1);
    clear_q();
  endtask

  int chk_cyc;
  int found;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_regs", reg_out, 0);
    check("rst_err", err_count, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Garbage then write reg5 = 0x3C.
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h55); send_byte(8'h85); send_byte(8'h3C);
    chk_cyc = cyc;
    send_byte(8'hB9);
    check("wr_reg_before", reg_at(5), 8'h00);
    @(negedge clk);
    check("wr_cycle", cyc - chk_cyc, 2);
    check("wr_reg_after", reg_at(5), 8'h3C);
    check("wr_tx_start", tx_start, 1);
    check("wr_tx_data", tx_data, 8'hAC);
    repeat (30) @(negedge clk);
    expect_resp("wr", 1, 8'hAC, 8'h00);
    check("wr_err", err_count, 0);

    // Read back reg5 while bytes arrive during EXEC/SEND/WAIT_HI/WAIT_LO.
    send_byte(8'h55); send_byte(8'h05);
    send_byte(8'h05);
    send_byte(8'h55); send_byte(8'h85); send_byte(8'h77); send_byte(8'hF2);
    repeat (40) @(negedge clk);
    if (tx_cyc_q.size() >= 2 && fall_q.size() >= 1)
      check("rd_second_gap", tx_cyc_q[1] - fall_q[0], 1);
    else
      check("rd_second_seen", 0, 1);
    expect_resp("rd", 2, 8'hAC, 8'h3C);
    check("rd_drop_reg5", reg_at(5), 8'h3C);
    check("rd_err", err_count, 0);

    // Bad checksum.
    send_byte(8'h55); send_byte(8'h81); send_byte(8'h11); send_byte(8'h00);
    repeat (20) @(negedge clk);
    expect_resp("badchk", 1, 8'hE0, 8'h00);
    check("badchk_reg1", reg_at(1), 8'h00);
    check("badchk_err", err_count, 1);

    // Address beyond NUM_REGS.
    send_byte(8'h55); send_byte(8'h0F); send_byte(8'h0F);
    repeat (20) @(negedge clk);
    expect_resp("badaddr", 1, 8'hE2, 8'h00);
    check("badaddr_err", err_count, 2);

    // Reserved CMD bits set, checksum correct.
    send_byte(8'h55); send_byte(8'h15); send_byte(8'h15);
    repeat (20) @(negedge clk);
    expect_resp("badcmd", 1, 8'hE1, 8'h00);

    // A second 0x55 is taken as CMD, not a resync.
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h55);
    repeat (20) @(negedge clk);
    expect_resp("sync_as_cmd", 1, 8'hE1, 8'h00);
    check("sync_as_cmd_err", err_count, 4);

    // Highest legal address.
    send_byte(8'h55); send_byte(8'h07); send_byte(8'h07);
    repeat (30) @(negedge clk);
    expect_resp("rd_top", 2, 8'hAC, 8'h00);

    // Timeout in GET_DATA.
    send_byte(8'h55); send_byte(8'h85);
    repeat (TMO) @(negedge clk);
    check("tmo_err_before", err_count, 4);
    @(negedge clk);
    check("tmo_err_after", err_count, 5);
    repeat (5) @(negedge clk);
    check("tmo_no_tx", tx_q.size(), 0);

    send_byte(8'h55); send_byte(8'h83); send_byte(8'h5A); send_byte(8'hD9);
    repeat (20) @(negedge clk);
    expect_resp("post_tmo", 1, 8'hAC, 8'h00);
    check("post_tmo_reg3", reg_at(3), 8'h5A);

    // Byte arriving on the expiry cycle wins.
    send_byte(8'h55); send_byte(8'h86);
    repeat (TMO) @(negedge clk);
    send_byte(8'h44); send_byte(8'hC2);
    repeat (20) @(negedge clk);
    expect_resp("tmo_edge", 1, 8'hAC, 8'h00);
    check("tmo_edge_reg6", reg_at(6), 8'h44);
    check("tmo_edge_err", err_count, 5);

    // Reset while waiting for tx_busy after the first byte of a read.
    send_byte(8'h55); send_byte(8'h05); send_byte(8'h05);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (tx_start) found = 1;
      else @(negedge clk);
    end
    check("rst_mid_seen_start", found, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_tx_start", tx_start, 0);
    check("rst_mid_tx_data", tx_data, 8'h00);
    check("rst_mid_regs", reg_out, 0);
    check("rst_mid_err", err_count, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    expect_resp("rst_mid", 1, 8'hAC, 8'h00);

    send_byte(8'h55); send_byte(8'h81); send_byte(8'h22); send_byte(8'hA3);
    repeat (20) @(negedge clk);
    expect_resp("post_rst", 1, 8'hAC, 8'h00);
    check("post_rst_reg1", reg_at(1), 8'h22);

    // err_count saturation.
    for (int k = 0; k < 256; k++) begin
      send_byte(8'h55); send_byte(8'h0F); send_byte(8'h0F);
      repeat (12) @(negedge clk);
    end
    check("err_saturate", err_count, 8'hFF);
    clear_q();

    check("tx_start_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
